// File: rtl/nn_load_ctrl.sv
// DMA-to-buffer loader: packs DMA beats into wide words, fills the image buffer, then ping-pong weight banks.
// Optional NN_LOAD_STALL_CNT_EN adds o_stall_cnt, a saturating count of back-pressured WGT beats.
module nn_load_ctrl #(
    parameter int unsigned DMA_WIDTH       = 16,
    parameter int unsigned WORD_BEATS      = 3,
    parameter int unsigned WORD_WIDTH      = DMA_WIDTH * WORD_BEATS,
    parameter int unsigned COLUMN_NUM      = 6,
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned WMEM_ADDR_WIDTH = 7,
    parameter int unsigned SET_WIDTH       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [IMEM_ADDR_WIDTH-1:0] i_img_words,
    input  logic [WMEM_ADDR_WIDTH-1:0] i_wgt_rows,
    input  logic [SET_WIDTH-1:0]       i_wgt_sets,
    input  logic                       i_dma_valid,
    input  logic [DMA_WIDTH-1:0]       i_dma_data,
    output logic                       o_dma_ready,
    output logic                       o_img_wr_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_img_wr_addr,
    output logic [WORD_WIDTH-1:0]      o_img_wr_data,
    output logic [COLUMN_NUM-1:0]      o_wmem_wr_en,
    output logic                       o_wmem_wr_bank,
    output logic [WMEM_ADDR_WIDTH-1:0] o_wmem_wr_addr,
    output logic [WORD_WIDTH-1:0]      o_wmem_wr_data,
    output logic [1:0]                 o_bank_full,
    input  logic [1:0]                 i_bank_release,
    output logic                       o_busy,
`ifdef NN_LOAD_STALL_CNT_EN
    output logic [15:0]                o_stall_cnt,
`endif
    output logic                       o_done
);

    localparam int unsigned BW = $clog2(WORD_BEATS);
    localparam int unsigned CW = (COLUMN_NUM > 1) ? $clog2(COLUMN_NUM) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORD_BEATS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLUMN_NUM - 1);

    typedef enum logic [1:0] {StIdle, StImg, StWgt, StDone} state_e;

    state_e                       state_q;
    logic [BW-1:0]                beat_q;
    logic [WORD_WIDTH-DMA_WIDTH-1:0] data_q;
    logic [IMEM_ADDR_WIDTH-1:0]   img_addr_q;
    logic [IMEM_ADDR_WIDTH-1:0]   img_words_q;
    logic [WMEM_ADDR_WIDTH-1:0]   wgt_rows_q;
    logic [SET_WIDTH-1:0]         wgt_sets_q;
    logic [CW-1:0]                col_q;
    logic [WMEM_ADDR_WIDTH-1:0]   row_q;
    logic [SET_WIDTH-1:0]         set_q;
    logic                         bank_ptr_q;

    logic                  dma_accept;
    logic                  last_beat;
    logic                  set_done;
    logic [1:0]            set_mask;
    logic [1:0]            bank_full_d;
    logic [WORD_WIDTH-1:0] word_w;

    // Ready is decoded from registered state so a release re-opens it one cycle later.
    assign o_dma_ready = (state_q == StImg) | ((state_q == StWgt) & ~o_bank_full[bank_ptr_q]);

    always_comb begin
        dma_accept  = i_dma_valid & o_dma_ready;
        last_beat   = (beat_q == LAST_BEAT);
        word_w      = {i_dma_data, data_q};
        set_done    = (state_q == StWgt) & dma_accept & last_beat &
                      (col_q == LAST_COL) & (row_q == wgt_rows_q);
        set_mask    = '0;
        if (set_done) begin
            set_mask[bank_ptr_q] = 1'b1;
        end
        bank_full_d = (o_bank_full & ~i_bank_release) | set_mask;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            data_q         <= '0;
            img_addr_q     <= '0;
            img_words_q    <= '0;
            wgt_rows_q     <= '0;
            wgt_sets_q     <= '0;
            col_q          <= '0;
            row_q          <= '0;
            set_q          <= '0;
            bank_ptr_q     <= 1'b0;
            o_img_wr_en    <= 1'b0;
            o_img_wr_addr  <= '0;
            o_img_wr_data  <= '0;
            o_wmem_wr_en   <= '0;
            o_wmem_wr_bank <= 1'b0;
            o_wmem_wr_addr <= '0;
            o_wmem_wr_data <= '0;
            o_bank_full    <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_img_wr_en  <= 1'b0;
            o_wmem_wr_en <= '0;
            o_done       <= 1'b0;
            o_bank_full  <= bank_full_d;

            // Partial beats are stored in place; the last beat goes straight to the write port.
            if (dma_accept && !last_beat) begin
                data_q[beat_q*DMA_WIDTH +: DMA_WIDTH] <= i_dma_data;
                beat_q <= beat_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q     <= StImg;
                        img_words_q <= i_img_words;
                        wgt_rows_q  <= i_wgt_rows;
                        wgt_sets_q  <= i_wgt_sets;
                        img_addr_q  <= '0;
                        beat_q      <= '0;
                        col_q       <= '0;
                        row_q       <= '0;
                        set_q       <= '0;
                        o_busy      <= 1'b1;
                    end
                end
                StImg: begin
                    if (dma_accept && last_beat) begin
                        beat_q        <= '0;
                        o_img_wr_en   <= 1'b1;
                        o_img_wr_addr <= img_addr_q;
                        o_img_wr_data <= word_w;
                        if (img_addr_q == img_words_q) begin
                            state_q <= (wgt_sets_q == '0) ? StDone : StWgt;
                        end else begin
                            img_addr_q <= img_addr_q + 1'b1;
                        end
                    end
                end
                StWgt: begin
                    if (dma_accept && last_beat) begin
                        beat_q         <= '0;
                        o_wmem_wr_en   <= COLUMN_NUM'(1) << col_q;
                        o_wmem_wr_bank <= bank_ptr_q;
                        o_wmem_wr_addr <= row_q;
                        o_wmem_wr_data <= word_w;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == wgt_rows_q) begin
                                row_q      <= '0;
                                bank_ptr_q <= ~bank_ptr_q;
                                set_q      <= set_q + 1'b1;
                                if (set_q + 1'b1 == wgt_sets_q) begin
                                    state_q <= StDone;
                                end
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef NN_LOAD_STALL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_stall_cnt <= '0;
        end else if (state_q == StIdle && i_start) begin
            o_stall_cnt <= '0;
        end else if (state_q == StWgt && i_dma_valid && !o_dma_ready &&
                     o_stall_cnt != 16'hFFFF) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_load_ctrl.sv
// Directed bench for nn_load_ctrl: image packing, weight rotation, ping-pong stall, reset abort.
module tb_nn_load_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_img_words = '0;
    logic [6:0]  i_wgt_rows = '0;
    logic [7:0]  i_wgt_sets = '0;
    logic        i_dma_valid = 1'b0;
    logic [15:0] i_dma_data = '0;
    logic        o_dma_ready;
    logic        o_img_wr_en;
    logic [9:0]  o_img_wr_addr;
    logic [47:0] o_img_wr_data;
    logic [5:0]  o_wmem_wr_en;
    logic        o_wmem_wr_bank;
    logic [6:0]  o_wmem_wr_addr;
    logic [47:0] o_wmem_wr_data;
    logic [1:0]  o_bank_full;
    logic [1:0]  i_bank_release = '0;
    logic        o_busy;
    logic        o_done;
`ifdef NN_LOAD_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    nn_load_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_img_words    (i_img_words),
        .i_wgt_rows     (i_wgt_rows),
        .i_wgt_sets     (i_wgt_sets),
        .i_dma_valid    (i_dma_valid),
        .i_dma_data     (i_dma_data),
        .o_dma_ready    (o_dma_ready),
        .o_img_wr_en    (o_img_wr_en),
        .o_img_wr_addr  (o_img_wr_addr),
        .o_img_wr_data  (o_img_wr_data),
        .o_wmem_wr_en   (o_wmem_wr_en),
        .o_wmem_wr_bank (o_wmem_wr_bank),
        .o_wmem_wr_addr (o_wmem_wr_addr),
        .o_wmem_wr_data (o_wmem_wr_data),
        .o_bank_full    (o_bank_full),
        .i_bank_release (i_bank_release),
        .o_busy         (o_busy),
`ifdef NN_LOAD_STALL_CNT_EN
        .o_stall_cnt    (o_stall_cnt),
`endif
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0][15:0] beats;
        logic [9:0]       addr;
        logic [5:0]       col_en;
        logic [6:0]       row;
        logic [47:0]      data;
    } vec_t;

    vec_t img_tab[2];
    vec_t wgt_tab[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    // Drive one beat after an optional idle gap; returns #1 after the accepting edge.
    task automatic send_beat(input logic [15:0] d, input int gap);
        int n = 0;
        i_dma_valid = 1'b0;
        repeat (gap) begin @(posedge i_clk); #1; end
        i_dma_valid = 1'b1;
        i_dma_data  = d;
        while (!o_dma_ready && n < 100) begin @(posedge i_clk); #1; n++; end
        if (!o_dma_ready) begin
            total++;
            $display("FAIL ready_timeout: got ready=0, expected ready=1");
        end
        @(posedge i_clk); #1;
        i_dma_valid = 1'b0;
    endtask

    task automatic send_word(input logic [2:0][15:0] b, input logic gaps);
        for (int k = 0; k < 3; k++) send_beat(b[k], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic start_load(input logic [9:0] iw, input logic [6:0] wr, input logic [7:0] ws);
        i_img_words = iw;
        i_wgt_rows  = wr;
        i_wgt_sets  = ws;
        i_start     = 1'b1;
        @(posedge i_clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 20) begin @(posedge i_clk); #1; n++; end
        check("done_pulse", o_done, 1);
        check("busy_after_done", o_busy, 0);
        @(posedge i_clk); #1;
        check("done_one_cycle", o_done, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        #13;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic run_image(input logic gaps);
        start_load(10'd1, 7'd0, 8'd0);
        check("busy_high", o_busy, 1);
        for (int i = 0; i < 2; i++) begin
            send_word(img_tab[i].beats, gaps);
            check($sformatf("img_en[%0d]", i), o_img_wr_en, 1);
            check($sformatf("img_addr[%0d]", i), o_img_wr_addr, img_tab[i].addr);
            check($sformatf("img_data[%0d]", i), o_img_wr_data, img_tab[i].data);
        end
        wait_done();
    endtask

    task automatic send_set(input int base);
        for (int i = 0; i < 6; i++) begin
            logic [2:0][15:0] b;
            b[0] = 16'h7000 + 16'(base + i);
            b[1] = 16'h8000 + 16'(base + i);
            b[2] = 16'h9000 + 16'(base + i);
            send_word(b, 1'b0);
            check("set_wr_data", o_wmem_wr_data, {b[2], b[1], b[0]});
        end
    endtask

    initial begin
        img_tab[0] = '{beats: {16'h3333, 16'h2222, 16'h1111}, addr: 10'd0, col_en: '0, row: '0,
                       data: 48'h3333_2222_1111};
        img_tab[1] = '{beats: {16'h6666, 16'h5555, 16'h4444}, addr: 10'd1, col_en: '0, row: '0,
                       data: 48'h6666_5555_4444};
        for (int i = 0; i < 12; i++) begin
            wgt_tab[i].beats  = {16'hC000 | 16'(i), 16'hB000 | 16'(i), 16'hA000 | 16'(i)};
            wgt_tab[i].addr   = '0;
            wgt_tab[i].col_en = 6'b000001 << (i % 6);
            wgt_tab[i].row    = 7'(i / 6);
            wgt_tab[i].data   = {16'hC000 | 16'(i), 16'hB000 | 16'(i), 16'hA000 | 16'(i)};
        end

        do_reset();
        check("por_busy", o_busy, 0);
        check("por_ready", o_dma_ready, 0);

        // Abort mid-image: two words and a partial beat, then asynchronous reset.
        start_load(10'd3, 7'd0, 8'd0);
        for (int i = 0; i < 7; i++) send_beat(16'hDEAD + 16'(i), 0);
        #3;
        i_rst = 1'b0;
        #1;
        check("rst_img_en", o_img_wr_en, 0);
        check("rst_img_addr", o_img_wr_addr, 0);
        check("rst_img_data", o_img_wr_data, 0);
        check("rst_wmem_en", o_wmem_wr_en, 0);
        check("rst_bank_full", o_bank_full, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_ready", o_dma_ready, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk); #1;

        // Image packing, then the same data with random valid gaps.
        run_image(1'b0);
        run_image(1'b1);

        // Weight rotation: one image word, then two rows of six columns into bank 0.
        do_reset();
        start_load(10'd0, 7'd1, 8'd1);
        send_word(img_tab[0].beats, 1'b0);
        check("wgt_img_data", o_img_wr_data, img_tab[0].data);
        for (int i = 0; i < 12; i++) begin
            send_word(wgt_tab[i].beats, 1'b0);
            check($sformatf("wgt_en[%0d]", i), o_wmem_wr_en, wgt_tab[i].col_en);
            check($sformatf("wgt_row[%0d]", i), o_wmem_wr_addr, wgt_tab[i].row);
            check($sformatf("wgt_bank[%0d]", i), o_wmem_wr_bank, 0);
            check($sformatf("wgt_data[%0d]", i), o_wmem_wr_data, wgt_tab[i].data);
        end
        check("wgt_bank_full", o_bank_full, 2'b01);
        wait_done();
        check("wgt_full_persists", o_bank_full, 2'b01);

        // Ping-pong: three one-row sets, stall with both banks full, then release bank 0.
        do_reset();
        start_load(10'd0, 7'd0, 8'd3);
        send_word(img_tab[1].beats, 1'b0);
        send_set(0);
        check("pp_bank_after_set1", o_bank_full, 2'b01);
        send_set(16);
        check("pp_set2_bank", o_wmem_wr_bank, 1);
        check("pp_bank_after_set2", o_bank_full, 2'b11);
        i_dma_valid = 1'b1;
        i_dma_data  = 16'h7020;
        check("pp_stall_ready", o_dma_ready, 0);
        repeat (9) begin
            @(posedge i_clk); #1;
            check("pp_stall_ready", o_dma_ready, 0);
        end
        i_bank_release = 2'b01;
        @(posedge i_clk); #1;
        i_bank_release = 2'b00;
        check("pp_release_full", o_bank_full, 2'b10);
        check("pp_release_ready", o_dma_ready, 1);
`ifdef NN_LOAD_STALL_CNT_EN
        check("stall_cnt", o_stall_cnt, 16'd10);
`endif
        send_beat(16'h7020, 0);
        send_beat(16'h8020, 0);
        send_beat(16'h9020, 0);
        check("pp_set3_bank", o_wmem_wr_bank, 0);
        check("pp_set3_col", o_wmem_wr_en, 6'b000001);
        check("pp_set3_data", o_wmem_wr_data, 48'h9020_8020_7020);
        for (int i = 1; i < 6; i++) begin
            logic [2:0][15:0] b;
            b[0] = 16'h7020 + 16'(i);
            b[1] = 16'h8020 + 16'(i);
            b[2] = 16'h9020 + 16'(i);
            send_word(b, 1'b0);
        end
        check("pp_set3_last_col", o_wmem_wr_en, 6'b100000);
        check("pp_final_full", o_bank_full, 2'b11);
        wait_done();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
